// File: rtl/uart_host_bridge.sv
// uart_host_bridge: bus initiator for the MiniUART slave port.
// It programs the baud divisors once after reset and then polls LSR continuously.
// Received bytes go into an RX FIFO, and bytes queued in a TX FIFO are written to DATA.
// Each strobe cycle is one complete access, so the bus outputs are decoded from the state register.
module uart_host_bridge #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [15:0] DIVR_INIT  = 16'd5208,
    parameter logic [15:0] DIVT_INIT  = 16'd5208,
    parameter int unsigned TX_GAP     = 2,
    parameter logic [2:0]  OFF_DATA   = 3'd0,
    parameter logic [2:0]  OFF_LSR    = 3'd1,
    parameter logic [2:0]  OFF_DIVR   = 3'd2,
    parameter logic [2:0]  OFF_DIVT   = 3'd3
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    output logic [2:0]  m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_stb_o,
    output logic        m_we_o,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned GAP_W = $clog2(TX_GAP + 1);

    localparam logic [2:0] ST_INIT_DIVR = 3'd0;
    localparam logic [2:0] ST_INIT_DIVT = 3'd1;
    localparam logic [2:0] ST_POLL      = 3'd2;
    localparam logic [2:0] ST_RD_DATA   = 3'd3;
    localparam logic [2:0] ST_RX_ACK    = 3'd4;
    localparam logic [2:0] ST_TX_WR     = 3'd5;
    localparam logic [2:0] ST_TX_GAP    = 3'd6;

    logic [2:0]       state;
    logic [GAP_W-1:0] gap_cnt;

    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_count;
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_count;

    logic rx_push, rx_pop, tx_push, tx_pop;
    logic rx_full, tx_full, tx_empty;
    logic rs, ts;
    logic unused_bits;

    // The count never exceeds DEPTH, so its top bit alone marks "full".
    assign rx_full  = rx_count[DEPTH_LOG2];
    assign tx_full  = tx_count[DEPTH_LOG2];
    assign tx_empty = (tx_count == '0);

    assign rs = m_dat_i[0];
    assign ts = m_dat_i[5];
    assign unused_bits = ^m_dat_i[31:8];

    assign rx_valid = (rx_count != '0);
    assign rx_data  = rx_mem[rx_rd_ptr];
    assign tx_ready = init_done && !tx_full;

    assign rx_push = (state == ST_RD_DATA);
    assign rx_pop  = rx_valid && rx_ready;
    assign tx_push = tx_valid && tx_ready;
    assign tx_pop  = (state == ST_TX_WR);

    // Sequence the bus accesses: divisor set-up, then the poll / read / ack / write loop.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= ST_INIT_DIVR;
            gap_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT_DIVR: state <= ST_INIT_DIVT;
                ST_INIT_DIVT: begin
                    state     <= ST_POLL;
                    init_done <= 1'b1;
                end
                ST_POLL: begin
                    if (rs && !rx_full) begin
                        state <= ST_RD_DATA;
                    end else if (ts && !tx_empty) begin
                        state <= ST_TX_WR;
                    end
                end
                ST_RD_DATA: state <= ST_RX_ACK;
                ST_RX_ACK:  state <= ST_POLL;
                ST_TX_WR: begin
                    state   <= ST_TX_GAP;
                    gap_cnt <= GAP_W'(TX_GAP - 1);
                end
                ST_TX_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_POLL;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= ST_INIT_DIVR;
            endcase
        end
    end

    // Decode the bus access from the state; reset forces the bus idle without waiting for a clock.
    always_comb begin
        m_stb_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = '0;
        m_dat_o = '0;
        case (state)
            ST_INIT_DIVR: begin
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = OFF_DIVR;
                m_dat_o = {16'b0, DIVR_INIT};
            end
            ST_INIT_DIVT: begin
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = OFF_DIVT;
                m_dat_o = {16'b0, DIVT_INIT};
            end
            ST_POLL: begin
                m_stb_o = 1'b1;
                m_adr_o = OFF_LSR;
            end
            ST_RD_DATA: begin
                m_stb_o = 1'b1;
                m_adr_o = OFF_DATA;
            end
            ST_RX_ACK: begin
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = OFF_LSR;
            end
            ST_TX_WR: begin
                m_stb_o = 1'b1;
                m_we_o  = 1'b1;
                m_adr_o = OFF_DATA;
                m_dat_o = {24'b0, tx_mem[tx_rd_ptr]};
            end
            default: ;
        endcase
        if (RST_I) begin
            m_stb_o = 1'b0;
            m_we_o  = 1'b0;
            m_adr_o = '0;
            m_dat_o = '0;
        end
    end

    // RX FIFO storage: capture the DATA register contents during the read cycle.
    always_ff @(posedge CLK_I) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= m_dat_i[7:0];
        end
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: ;
            endcase
        end
    end

    // TX FIFO storage: accept client bytes.
    always_ff @(posedge CLK_I) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    // TX FIFO pointers and occupancy; the head is consumed by the DATA write.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule
